// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: state encoding, DSP mode codes and per-mode run lengths
// shared by the DSP op sequencer and its bench.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam logic [1:0] MODE_17X17   = 2'd0;
  localparam logic [1:0] MODE_17X33   = 2'd1;
  localparam logic [1:0] MODE_33X33   = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int unsigned CYC_17X17 = 1;
  localparam int unsigned CYC_17X33 = 2;
  localparam int unsigned CYC_33X33 = 4;

  // Number of cycles the DSP needs before its output is final for a mode.
  function automatic int unsigned mode_cycles(input logic [1:0] mode);
    case (mode)
      MODE_17X17: return CYC_17X17;
      MODE_17X33: return CYC_17X33;
      MODE_33X33: return CYC_33X33;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/dsp_seq_perf.sv
// dsp_seq_perf: completed-operation and busy-cycle counters for the DSP op
// sequencer. Only instantiated when DSP_SEQ_PERF_EN is defined.
module dsp_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ops_inc,
  input  logic        busy_inc,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy
);

  // Free-running counters that wrap at 2^32; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (ops_inc)  perf_ops  <= perf_ops + 32'd1;
      if (busy_inc) perf_busy <= perf_busy + 32'd1;
    end
  end

endmodule

// File: rtl/dsp_op_sequencer.sv
// dsp_op_sequencer: command-level controller in front of DSP_top. Accepts one
// multiply-add command, drives the DSP pins for the cycles the mode needs,
// captures the sum and hands it back over a result handshake. cmd_acc steers
// the previous result in as the addend.
// Optional: define DSP_SEQ_PERF_EN to add perf_ops/perf_busy counters.
module dsp_op_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [2*WIDTH-1:0]   cmd_c,
  input  logic                 cmd_acc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_err,
  output logic                 dsp_start,
  output logic [1:0]           dsp_mode,
  output logic [WIDTH-1:0]     dsp_aa,
  output logic [WIDTH-1:0]     dsp_bb,
  output logic [2*WIDTH-1:0]   dsp_cc,
  output logic                 dsp_mac,
  output logic [1:0]           dsp_shift_amount,
  output logic                 dsp_shift_dir,
  input  logic [2*WIDTH-1:0]   dsp_out
`ifdef DSP_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_busy
`endif
);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               last_run;

  // The DSP's own MAC and shifter are never used by this controller.
  assign dsp_mac          = 1'b0;
  assign dsp_shift_amount = 2'd0;
  assign dsp_shift_dir    = 1'b0;

  assign last_run = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  // State register; reset drops any in-flight command.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_mode == MODE_ILLEGAL) ? ST_ERR : ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_ERR: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: register the command on accept, count down the run, capture
  // the DSP sum on the last run cycle. dsp_start pulses for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_start <= 1'b0;
      dsp_mode  <= 2'd0;
      dsp_aa    <= '0;
      dsp_bb    <= '0;
      dsp_cc    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      dsp_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_mode != MODE_ILLEGAL) begin
            dsp_start <= 1'b1;
            dsp_mode  <= cmd_mode;
            dsp_aa    <= cmd_a;
            dsp_bb    <= cmd_b;
            dsp_cc    <= cmd_acc ? acc_q : cmd_c;
            cnt_q     <= CNT_W'(mode_cycles(cmd_mode));
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_run) begin
            res_data <= dsp_out;
            acc_q    <= dsp_out;
            res_err  <= 1'b0;
          end
        end
        ST_ERR: begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DSP_SEQ_PERF_EN
  dsp_seq_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .ops_inc   (last_run),
    .busy_inc  (state_q != ST_IDLE),
    .perf_ops  (perf_ops),
    .perf_busy (perf_busy)
  );
`else
  // Performance counters are not built; sequencing is unaffected.
`endif

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// tb_dsp_op_sequencer: directed and randomized checks of the DSP op sequencer
// against a transaction-level model (result = A*B + addend per mode, plus an
// accumulator). A DSP stand-in drives dsp_out and only presents the true sum
// in the final cycle of a run, so early capture shows up as a wrong result.
module tb_dsp_op_sequencer;
  import dsp_seq_pkg::*;

  localparam int WIDTH = 33;
  localparam int RW    = 2 * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [WIDTH-1:0]  cmd_a;
  logic [WIDTH-1:0]  cmd_b;
  logic [RW-1:0]     cmd_c;
  logic              cmd_acc;
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     res_data;
  logic              res_err;
  logic              dsp_start;
  logic [1:0]        dsp_mode;
  logic [WIDTH-1:0]  dsp_aa;
  logic [WIDTH-1:0]  dsp_bb;
  logic [RW-1:0]     dsp_cc;
  logic              dsp_mac;
  logic [1:0]        dsp_shift_amount;
  logic              dsp_shift_dir;
  logic [RW-1:0]     dsp_out;
`ifdef DSP_SEQ_PERF_EN
  logic [31:0]       perf_ops;
  logic [31:0]       perf_busy;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [RW-1:0] model_acc = '0;

  always #5 clk = ~clk;

  dsp_op_sequencer #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_mode         (cmd_mode),
    .cmd_a            (cmd_a),
    .cmd_b            (cmd_b),
    .cmd_c            (cmd_c),
    .cmd_acc          (cmd_acc),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_err          (res_err),
    .dsp_start        (dsp_start),
    .dsp_mode         (dsp_mode),
    .dsp_aa           (dsp_aa),
    .dsp_bb           (dsp_bb),
    .dsp_cc           (dsp_cc),
    .dsp_mac          (dsp_mac),
    .dsp_shift_amount (dsp_shift_amount),
    .dsp_shift_dir    (dsp_shift_dir),
    .dsp_out          (dsp_out)
`ifdef DSP_SEQ_PERF_EN
    ,
    .perf_ops         (perf_ops),
    .perf_busy        (perf_busy)
`endif
  );

  // Unsigned multiply-add with per-mode operand truncation, wrapping at 2^RW.
  function automatic logic [RW-1:0] model_mac(input logic [1:0] mode,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [RW-1:0] addend);
    logic [RW-1:0] ma, mb;
    ma = RW'(a);
    mb = RW'(b);
    if (mode == 2'd0 || mode == 2'd1) ma = RW'(a[16:0]);
    if (mode == 2'd0)                 mb = RW'(b[16:0]);
    return ma * mb + addend;
  endfunction

  function automatic int run_len(input logic [1:0] mode);
    case (mode)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 1;
    endcase
  endfunction

  // DSP stand-in: correct sum only in the last cycle of a run, inverted otherwise.
  int            stub_k = 0;
  int            stub_cyc;
  logic [RW-1:0] stub_sum;

  always_ff @(posedge clk) begin
    if (dsp_start)                     stub_k <= 2;
    else if (stub_k != 0 && stub_k < 15) stub_k <= stub_k + 1;
  end

  always_comb begin
    stub_sum = model_mac(dsp_mode, dsp_aa, dsp_bb, dsp_cc);
    stub_cyc = dsp_start ? 1 : stub_k;
    dsp_out  = (stub_cyc == run_len(dsp_mode)) ? stub_sum : ~stub_sum;
  end

  task automatic check(input string tag, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cmd();
    cmd_mode = 2'($urandom_range(0, 3));
    cmd_a    = WIDTH'({$urandom, $urandom});
    cmd_b    = WIDTH'({$urandom, $urandom});
    cmd_c    = RW'({$urandom, $urandom, $urandom});
    cmd_acc  = 1'($urandom_range(0, 1));
  endtask

  // Issue one command, check pins/latency/result, hold the result for `hold`
  // cycles with a competing command presented, then release it.
  task automatic run_op(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [RW-1:0] c,
                        input logic acc, input int hold,
                        output logic [RW-1:0] got);
    logic [RW-1:0] addend, exp;
    int            n, lat;
    addend = acc ? model_acc : c;
    n      = run_len(mode);
    exp    = (mode == 2'd3) ? '0 : model_mac(mode, a, b, addend);
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    check("idle_cmd_ready", RW'(cmd_ready), RW'(1));
    cmd_mode = mode; cmd_a = a; cmd_b = b; cmd_c = c; cmd_acc = acc;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    scramble_cmd();
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (res_valid) begin
        lat = k;
        break;
      end
      if (k == 1) begin
        check("busy_cmd_ready", RW'(cmd_ready), RW'(0));
        check("tied_pins", RW'({dsp_mac, dsp_shift_amount, dsp_shift_dir}), RW'(0));
      end
      if (mode != 2'd3 && k <= n) begin
        check("dsp_start", RW'(dsp_start), RW'(k == 1));
        check("dsp_mode", RW'(dsp_mode), RW'(mode));
        check("dsp_aa", RW'(dsp_aa), RW'(a));
        check("dsp_bb", RW'(dsp_bb), RW'(b));
        check("dsp_cc", dsp_cc, addend);
      end
      tick();
    end
    check("latency", RW'(lat), RW'(n + 1));
    got = res_data;
    check("res_data", res_data, exp);
    check("res_err", RW'(res_err), RW'(mode == 2'd3));
    if (mode != 2'd3) model_acc = exp;
    for (int h = 0; h < hold; h++) begin
      scramble_cmd();
      cmd_valid = 1'b1;
      check("hold_valid", RW'(res_valid), RW'(1));
      check("hold_data", res_data, exp);
      check("hold_cmd_ready", RW'(cmd_ready), RW'(0));
      check("hold_no_start", RW'(dsp_start), RW'(0));
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("released_valid", RW'(res_valid), RW'(0));
    check("released_ready", RW'(cmd_ready), RW'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] got;
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_mode = 2'd0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_acc = 1'b0;
    tick(); tick();
    check("rst_res_valid", RW'(res_valid), RW'(0));
    check("rst_res_err", RW'(res_err), RW'(0));
    check("rst_res_data", res_data, RW'(0));
    check("rst_dsp_start", RW'(dsp_start), RW'(0));
    check("rst_dsp_pins", RW'({dsp_mode, dsp_aa, dsp_bb}), RW'(0));
    check("rst_dsp_cc", dsp_cc, RW'(0));
    rst = 1'b0;
    check("rst_cmd_ready", RW'(cmd_ready), RW'(1));

    // Directed cases with hand-computed results.
    run_op(2'd0, 33'd3, 33'd5, 66'd7, 1'b0, 0, got);
    check("tp_mode0", got, 66'd22);
    run_op(2'd0, 33'd2, 33'd2, 66'h3_dead_beef, 1'b1, 5, got);
    check("tp_acc", got, 66'd26);
    run_op(2'd2, 33'h1_0000_0001, 33'd2, 66'd0, 1'b0, 0, got);
    check("tp_mode2", got, 66'h2_0000_0002);
    run_op(2'd1, 33'h0_0001_FFFF, 33'h1_0000_0000, 66'd1, 1'b0, 1, got);
    check("tp_mode1", got, 66'h1_FFFF_0000_0001);
    run_op(2'd3, 33'd9, 33'd9, 66'd9, 1'b0, 1, got);
    check("tp_err_data", got, 66'd0);
    run_op(2'd0, 33'd5, 33'd6, 66'd123, 1'b1, 0, got);
    check("tp_acc_after_err", got, 66'h1_FFFF_0000_001F);

    // Reset during the second run cycle of a 33x33 op.
    cmd_mode = 2'd2; cmd_a = 33'h1_2345_6789; cmd_b = 33'd77; cmd_c = 66'd5;
    cmd_acc = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_acc = '0;
    check("midrst_valid", RW'(res_valid), RW'(0));
    check("midrst_ready", RW'(cmd_ready), RW'(1));
    check("midrst_start", RW'(dsp_start), RW'(0));
    for (int i = 0; i < 6; i++) tick();
    check("midrst_dropped", RW'(res_valid), RW'(0));
    run_op(2'd0, 33'd4, 33'd4, 66'h2_0000_0000_0000_0001, 1'b1, 0, got);
    check("tp_post_rst", got, 66'd16);

    // Randomized traffic, biased toward all-ones operands now and then.
    for (int t = 0; t < 200; t++) begin
      logic [1:0]       m;
      logic [WIDTH-1:0] a, b;
      logic [RW-1:0]    c;
      m = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? '1 : WIDTH'({$urandom, $urandom});
      b = ($urandom_range(0, 3) == 0) ? '1 : WIDTH'({$urandom, $urandom});
      c = ($urandom_range(0, 3) == 0) ? '1 : RW'({$urandom, $urandom, $urandom});
      run_op(m, a, b, c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
